// File: rtl/square_period_meter_pkg.sv
// Shared constants, state encoding and slicer helper for the square-wave period meter.
package square_period_meter_pkg;

  localparam int unsigned WIDTH_DEF   = 20;
  localparam logic [7:0]  HYST_HI_DEF = 8'd160;
  localparam logic [7:0]  HYST_LO_DEF = 8'd96;

  // Saturation / timeout value of the interval counter at the default width.
  localparam logic [WIDTH_DEF-1:0] CNT_MAX = '1;

  // IDLE: no edge seen yet, ARMED: one edge but no interval, TRACK: intervals measured.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

  // Hysteresis decision: go high at or above hi, low at or below lo, else hold.
  function automatic logic slice_next(input logic [7:0] sample,
                                      input logic [7:0] hi,
                                      input logic [7:0] lo,
                                      input logic       cur);
    logic nxt;
    if (sample >= hi) begin
      nxt = 1'b1;
    end else if (sample <= lo) begin
      nxt = 1'b0;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/square_period_meter_hyst_slicer.sv
// Hysteresis slicer: turns the 8-bit sample stream into one registered level bit
// and flags the cycle in which that level is about to change.
module square_period_meter_hyst_slicer
  import square_period_meter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_sample,
  input  logic [7:0] hyst_hi,
  input  logic [7:0] hyst_lo,
  output logic       edge_s
);

  logic level_q;
  logic level_d;

  // Next level from the hysteresis band; an edge is any change of level.
  always_comb begin
    level_d = slice_next(in_sample, hyst_hi, hyst_lo, level_q);
    edge_s  = (level_d != level_q);
  end

  // Level register, cleared to low on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/square_period_meter.sv
// Square-wave period meter: times the interval between slicer edges and reports it
// in the generator's FREQ encoding, with lock qualification and target matching.
module square_period_meter
  import square_period_meter_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter logic [7:0]  HYST_HI    = HYST_HI_DEF,
  parameter logic [7:0]  HYST_LO    = HYST_LO_DEF,
  parameter int unsigned TOL        = 4,
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [7:0]       IN,
  input  logic [WIDTH-1:0] TARGET,
  output logic [WIDTH-1:0] HALF_PERIOD,
  output logic             VALID,
  output logic             LOCKED,
  output logic             MATCH,
  output logic             STALE
);

  localparam logic [WIDTH-1:0] SAT    = '1;
  localparam logic [WIDTH-1:0] TOL_W  = WIDTH'(TOL);
  localparam int unsigned      MC_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [MC_W-1:0]  LOCK_N = MC_W'(LOCK_COUNT);

  // Unsigned distance without wrap-around.
  function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

  logic             edge_s;
  logic             cnt_at_max_s;
  logic             pair_agree_s;
  logic             target_ok_s;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] hp_q,     hp_d;
  logic             valid_q,  valid_d;
  logic             stale_q,  stale_d;
  logic             locked_q, locked_d;
  logic             match_q,  match_d;
  logic [MC_W-1:0]  mc_q,     mc_d;

  square_period_meter_hyst_slicer u_hyst_slicer (
    .clk       (CLOCK),
    .rst       (RESET),
    .in_sample (IN),
    .hyst_hi   (HYST_HI),
    .hyst_lo   (HYST_LO),
    .edge_s    (edge_s)
  );

  // Comparisons shared by the FSM: counter saturation, pair agreement, target agreement.
  always_comb begin
    cnt_at_max_s = (cnt_q == SAT);
    pair_agree_s = (abs_diff(cnt_q, hp_q) <= TOL_W);
    target_ok_s  = (abs_diff(cnt_q, TARGET) <= TOL_W);
  end

  // Interval counter, FSM next state, measurement, lock and match update.
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    valid_d = 1'b0;
    stale_d = stale_q;
    mc_d    = mc_q;

    // cnt restarts at every edge so that at the next edge it holds the gap length minus one.
    if (edge_s) begin
      cnt_d = '0;
    end else if (cnt_at_max_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (edge_s) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED, ST_TRACK: begin
        if (edge_s && !cnt_at_max_s) begin
          state_d = ST_TRACK;
          valid_d = 1'b1;
          hp_d    = cnt_q;
          stale_d = 1'b0;
          // The first interval has no predecessor to agree with.
          if (state_q == ST_ARMED) begin
            mc_d = '0;
          end else if (pair_agree_s) begin
            mc_d = (mc_q == LOCK_N) ? mc_q : mc_q + MC_W'(1);
          end else begin
            mc_d = '0;
          end
        end else if (edge_s) begin
          // Overrange: the edge is usable as a new start point but the interval is not.
          state_d = ST_ARMED;
          mc_d    = '0;
        end else if (cnt_at_max_s) begin
          // Timeout: signal lost, wait for a fresh pair of edges.
          state_d = ST_IDLE;
          stale_d = 1'b1;
          mc_d    = '0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stale_d = 1'b1;
        mc_d    = '0;
      end
    endcase

    locked_d = (mc_d == LOCK_N);

    // MATCH follows each new measurement and drops whenever lock is lost.
    if (valid_d) begin
      match_d = locked_d && target_ok_s;
    end else if (locked_d) begin
      match_d = match_q;
    end else begin
      match_d = 1'b0;
    end
  end

  // State, counter and output registers, all cleared asynchronously.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hp_q     <= '0;
      valid_q  <= 1'b0;
      stale_q  <= 1'b1;
      locked_q <= 1'b0;
      match_q  <= 1'b0;
      mc_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hp_q     <= hp_d;
      valid_q  <= valid_d;
      stale_q  <= stale_d;
      locked_q <= locked_d;
      match_q  <= match_d;
      mc_q     <= mc_d;
    end
  end

  assign HALF_PERIOD = hp_q;
  assign VALID       = valid_q;
  assign LOCKED      = locked_q;
  assign MATCH       = match_q;
  assign STALE       = stale_q;

endmodule

// File: tb/tb_square_period_meter.sv
// Self-checking bench for square_period_meter: table of tone scenarios, hand-written
// corner sequences and randomized edges, all compared against an edge-timestamp model.
module tb_square_period_meter;

  localparam int W   = 12;
  localparam int SAT = (1 << W) - 1;
  localparam int TOL = 4;

  logic         CLOCK;
  logic         RESET;
  logic [7:0]   IN;
  logic [W-1:0] TARGET;
  logic [W-1:0] HALF_PERIOD;
  logic         VALID;
  logic         LOCKED;
  logic         MATCH;
  logic         STALE;

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  square_period_meter #(.WIDTH(W)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .IN          (IN),
    .TARGET      (TARGET),
    .HALF_PERIOD (HALF_PERIOD),
    .VALID       (VALID),
    .LOCKED      (LOCKED),
    .MATCH       (MATCH),
    .STALE       (STALE)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no end of test, required end before time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: slicer level, time of last edge, and the list of intervals
  // measured since the last loss of tracking.
  int  cyc;
  int  m_last;
  bit  m_level, m_armed, m_valid, m_locked, m_match, m_stale;
  int  m_hp;
  int  meas[$];

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_reset();
    m_level = 1'b0; m_armed = 1'b0; m_valid = 1'b0; m_locked = 1'b0;
    m_match = 1'b0; m_stale = 1'b1; m_hp = 0; m_last = 0; cyc = 0;
    meas.delete();
  endtask

  task automatic model_step(input logic [7:0] v);
    bit nl;
    int gap;
    bit ok;
    cyc++;
    nl = (v >= 8'd160) ? 1'b1 : ((v <= 8'd96) ? 1'b0 : m_level);
    m_valid = 1'b0;
    gap = cyc - m_last - 1;
    if (nl != m_level) begin
      m_level = nl;
      if (!m_armed) begin
        m_armed = 1'b1;
      end else if (gap >= SAT) begin
        meas.delete(); m_locked = 1'b0; m_match = 1'b0;
      end else begin
        m_valid = 1'b1; m_hp = gap; m_stale = 1'b0;
        meas.push_back(gap);
        ok = (meas.size() >= 4);
        if (ok) begin
          for (int i = meas.size() - 3; i < meas.size(); i++) begin
            if (absd(meas[i], meas[i-1]) > TOL) ok = 1'b0;
          end
        end
        m_locked = ok;
        m_match  = ok && (absd(gap, int'(TARGET)) <= TOL);
      end
      m_last = cyc;
    end else if (m_armed && gap >= SAT) begin
      m_armed = 1'b0; m_stale = 1'b1; m_locked = 1'b0; m_match = 1'b0;
      meas.delete();
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cmp_cycle();
    checks++;
    if (VALID !== m_valid || HALF_PERIOD !== W'(m_hp) || LOCKED !== m_locked ||
        MATCH !== m_match || STALE !== m_stale) begin
      errors++;
      $display("FAIL cycle %0d: got v=%b hp=%0d l=%b m=%b s=%b, required v=%b hp=%0d l=%b m=%b s=%b",
               cyc, VALID, HALF_PERIOD, LOCKED, MATCH, STALE,
               m_valid, m_hp, m_locked, m_match, m_stale);
    end
  endtask

  task automatic tick(input logic [7:0] v);
    IN = v;
    @(posedge CLOCK);
    #1;
    model_step(v);
    if (VALID === 1'b1) vcount++;
    cmp_cycle();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    RESET = 1'b1;
    #2;
    chk("rst_half_period", HALF_PERIOD, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_match", MATCH, 0);
    chk("rst_stale", STALE, 1);
    model_reset();
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    vcount = 0;
  endtask

  // Square wave: edge e holds its level for (half+1) cycles; last edge holds 3.
  task automatic tone(input logic [7:0] hi, input logic [7:0] lo,
                      input int a, input int b, input int n);
    logic [7:0] v;
    int hold;
    for (int e = 0; e < n; e++) begin
      v    = (e % 2 == 0) ? hi : lo;
      hold = (e == n - 1) ? 3 : (((e % 2 == 0) ? a : b) + 1);
      for (int k = 0; k < hold; k++) tick(v);
    end
  endtask

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    int         a;
    int         b;
    int         edges;
    int         target;
    int         exp_valids;
    int         exp_hp;
    logic       exp_locked;
    logic       exp_match;
    logic       exp_stale;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0;
    IN = 8'd0;
    TARGET = '0;

    // Scaled tone (FREQ 1893) and the spec's lock / hysteresis / tolerance scenarios.
    vecs[0] = '{8'd255, 8'd0,   1893, 1893, 5,  1893, 4, 1893, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'd150, 8'd100, 9,    9,    20, 9,    0, 0,    1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'd200, 8'd50,  6,    6,    10, 100,  9, 6,    1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'd255, 8'd0,   1000, 1003, 5,  1003, 4, 1003, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'd255, 8'd0,   1000, 1010, 5,  1010, 4, 1010, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'd255, 8'd0,   300,  304,  5,  308,  4, 304,  1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'd255, 8'd0,   300,  305,  5,  305,  4, 305,  1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'd255, 8'd0,   300,  304,  5,  309,  4, 304,  1'b1, 1'b0, 1'b0};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      TARGET = W'(vecs[i].target);
      do_reset();
      tone(vecs[i].hi, vecs[i].lo, vecs[i].a, vecs[i].b, vecs[i].edges);
      chk($sformatf("vec%0d_valids", i), vcount, vecs[i].exp_valids);
      chk($sformatf("vec%0d_half_period", i), HALF_PERIOD, vecs[i].exp_hp);
      chk($sformatf("vec%0d_locked", i), LOCKED, vecs[i].exp_locked);
      chk($sformatf("vec%0d_match", i), MATCH, vecs[i].exp_match);
      chk($sformatf("vec%0d_stale", i), STALE, vecs[i].exp_stale);
    end

    // Timeout after lock, then recovery needs two edges.
    TARGET = W'(300);
    do_reset();
    tone(8'd255, 8'd0, 300, 300, 5);
    chk("to_locked_before", LOCKED, 1);
    for (int k = 0; k < SAT + 5; k++) tick(8'd255);
    chk("to_stale", STALE, 1);
    chk("to_locked", LOCKED, 0);
    chk("to_match", MATCH, 0);
    vcount = 0;
    tick(8'd0);
    for (int k = 0; k < 300; k++) tick(8'd0);
    chk("to_first_edge_no_valid", vcount, 0);
    tick(8'd255);
    chk("to_second_edge_valid", VALID, 1);
    chk("to_second_edge_hp", HALF_PERIOD, 300);

    // Edge exactly at saturation: overrange, no VALID, stays armed.
    do_reset();
    tick(8'd255);
    for (int k = 0; k < SAT; k++) tick(8'd255);
    tick(8'd0);
    chk("ovr_no_valid", VALID, 0);
    chk("ovr_stale", STALE, 1);
    for (int k = 0; k < 99; k++) tick(8'd0);
    tick(8'd255);
    chk("ovr_next_valid", VALID, 1);
    chk("ovr_next_hp", HALF_PERIOD, 99);

    // Reset mid-interval while locked; first edge after release gives no VALID.
    TARGET = W'(300);
    do_reset();
    tone(8'd255, 8'd0, 300, 300, 5);
    chk("rm_locked_before", LOCKED, 1);
    chk("rm_match_before", MATCH, 1);
    for (int k = 0; k < 150; k++) tick(8'd255);
    do_reset();
    tick(8'd255);
    chk("rm_first_edge_no_valid", VALID, 0);
    for (int k = 0; k < 50; k++) tick(8'd255);
    tick(8'd0);
    chk("rm_second_edge_valid", VALID, 1);
    chk("rm_second_edge_hp", HALF_PERIOD, 50);

    // Randomized edges with jittered intervals and in-band noise between edges.
    for (int r = 0; r < 3; r++) begin
      TARGET = W'($urandom_range(44, 54));
      do_reset();
      for (int e = 0; e < 40; e++) begin
        int hold;
        hold = 45 + $urandom_range(0, 8 + 2 * r);
        if (e % 2 == 0) begin
          v0 = $urandom_range(160, 255);
          tick(8'(v0));
          for (int k = 0; k < hold; k++) tick(8'($urandom_range(97, 255)));
        end else begin
          v0 = $urandom_range(0, 96);
          tick(8'(v0));
          for (int k = 0; k < hold; k++) tick(8'($urandom_range(0, 159)));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
